// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states,
// opcode constants, instruction classes, ALU op / operand selects,
// write-back selects, PC sources and trap causes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_HALT, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILL
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU op = {funct7_5, funct3} for the variants that use funct7_5
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction decode: opcode -> instruction class, and
// opcode/funct3/funct7_5 -> ALU operation.
//   i_opcode, i_funct3, i_funct7_5 : instruction fields
//   o_cls                          : instruction class (CLS_ILL if unknown)
//   o_alu_op                       : ALU operation for the EXECUTE step
module opcode_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output cls_e       o_cls,
  output logic [3:0] o_alu_op
);

  cls_e w_cls;

  always_comb begin
    w_cls = CLS_ILL;
    case (i_opcode)
      OP_R:      w_cls = CLS_R;
      OP_I:      w_cls = CLS_I;
      OP_LOAD:   w_cls = CLS_LOAD;
      OP_STORE:  w_cls = CLS_STORE;
      OP_BRANCH: w_cls = CLS_BRANCH;
      OP_JAL:    w_cls = CLS_JAL;
      OP_JALR:   w_cls = CLS_JALR;
      OP_LUI:    w_cls = CLS_LUI;
      OP_AUIPC:  w_cls = CLS_AUIPC;
      default:   w_cls = CLS_ILL;
    endcase
  end

  always_comb begin
    o_alu_op = ALU_ADD;
    case (w_cls)
      // funct7_5 only distinguishes ADD/SUB and SRL/SRA
      CLS_R:      o_alu_op = (i_funct3 == 3'd0 || i_funct3 == 3'd5) ?
                             {i_funct7_5, i_funct3} : {1'b0, i_funct3};
      // ADDI has no SUBI; only the shift-right immediate uses funct7_5
      CLS_I:      o_alu_op = (i_funct3 == 3'd5) ?
                             {i_funct7_5, i_funct3} : {1'b0, i_funct3};
      CLS_BRANCH: o_alu_op = ALU_SUB;
      default:    o_alu_op = ALU_ADD;
    endcase
  end

  assign o_cls = w_cls;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// plus sticky HALT and TRAP). Outputs decode from the state and the class
// latched in DECODE; FETCH and BRANCH also look at mem_ready/branch_taken.
//   i_clk, i_reset (async, active low)
//   i_opcode/i_funct3/i_funct7_5 : instruction fields from the IR
//   i_branch_taken, i_mem_ready, i_tr (halt request)
//   o_pc_write/o_pc_src, o_ir_write, o_mem_read/o_mem_write, o_iord,
//   o_reg_write, o_alu_src_a/b, o_alu_op, o_wb_sel : datapath controls
//   o_halted, o_trap, o_trap_cause, o_instret : status
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_5,
  input  logic        i_branch_taken,
  input  logic        i_mem_ready,
  input  logic        i_tr,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_src,
  output logic        o_ir_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_iord,
  output logic        o_reg_write,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_wb_sel,
  output logic        o_halted,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [31:0] o_instret
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  state_e        r_state;
  cls_e          r_cls;
  logic [3:0]    r_alu_op;
  logic [WW-1:0] r_wait;
  logic [1:0]    r_cause;
  logic [31:0]   r_instret;

  cls_e       w_cls;
  logic [3:0] w_alu_op;
  logic       w_timeout;
  state_e     w_done_state;

  opcode_decoder u_dec (
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_funct7_5 (i_funct7_5),
    .o_cls      (w_cls),
    .o_alu_op   (w_alu_op)
  );

  // This stalled cycle is the MAX_WAIT-th in a row for the current access.
  assign w_timeout    = !i_mem_ready && (r_wait == WW'(MAX_WAIT - 1));
  // Where a completing instruction goes: a pending halt request wins.
  assign w_done_state = i_tr ? ST_HALT : ST_FETCH;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_FETCH;
      r_cls     <= CLS_ILL;
      r_alu_op  <= ALU_ADD;
      r_wait    <= '0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      // Counter only survives across stalled cycles of one access.
      r_wait <= '0;
      case (r_state)
        ST_FETCH: begin
          if (i_mem_ready) r_state <= ST_DECODE;
          else if (w_timeout) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_TIMEOUT;
          end else begin
            r_wait <= r_wait + WW'(1);
            if (i_tr) r_state <= ST_HALT;
          end
        end
        ST_DECODE: begin
          r_cls    <= w_cls;
          r_alu_op <= w_alu_op;
          if (w_cls == CLS_ILL) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_ILLEGAL;
          end else r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          case (r_cls)
            CLS_BRANCH, CLS_JAL, CLS_JALR: begin
              r_state   <= w_done_state;
              r_instret <= r_instret + 32'd1;
            end
            CLS_LOAD, CLS_STORE: r_state <= ST_MEMORY;
            default:             r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEMORY: begin
          if (i_mem_ready) begin
            if (r_cls == CLS_LOAD) r_state <= ST_WRITEBACK;
            else begin
              r_state   <= w_done_state;
              r_instret <= r_instret + 32'd1;
            end
          end else if (w_timeout) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_TIMEOUT;
          end else r_wait <= r_wait + WW'(1);
        end
        ST_WRITEBACK: begin
          r_state   <= w_done_state;
          r_instret <= r_instret + 32'd1;
        end
        default: ; // HALT and TRAP hold until reset
      endcase
    end
  end

  always_comb begin
    o_pc_write  = 1'b0;
    o_pc_src    = PC_PLUS4;
    o_ir_write  = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_iord      = 1'b0;
    o_reg_write = 1'b0;
    o_alu_src_a = SRCA_PC;
    o_alu_src_b = SRCB_RS2;
    o_alu_op    = ALU_ADD;
    o_wb_sel    = WB_ALU;
    // Gated by reset so strobes drop the instant reset asserts.
    if (i_reset) begin
      case (r_state)
        ST_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = SRCB_4;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        ST_EXECUTE, ST_MEMORY, ST_WRITEBACK: begin
          // Operand selects stay stable so the ALU result (address or
          // value) is held through MEMORY and WRITEBACK.
          o_alu_op = r_alu_op;
          case (r_cls)
            CLS_R, CLS_BRANCH: begin
              o_alu_src_a = SRCA_RS1;
              o_alu_src_b = SRCB_RS2;
            end
            CLS_AUIPC, CLS_JAL: begin
              o_alu_src_a = SRCA_OLDPC;
              o_alu_src_b = SRCB_IMM;
            end
            default: begin
              o_alu_src_a = SRCA_RS1;
              o_alu_src_b = SRCB_IMM;
            end
          endcase
          if (r_state == ST_EXECUTE) begin
            case (r_cls)
              CLS_BRANCH: begin
                o_pc_write = i_branch_taken;
                o_pc_src   = PC_TARGET;
              end
              CLS_JAL, CLS_JALR: begin
                o_pc_write  = 1'b1;
                o_pc_src    = (r_cls == CLS_JAL) ? PC_TARGET : PC_JALR;
                o_reg_write = 1'b1;
                o_wb_sel    = WB_PC4;
              end
              default: ;
            endcase
          end else if (r_state == ST_MEMORY) begin
            o_iord      = 1'b1;
            o_mem_read  = (r_cls == CLS_LOAD);
            o_mem_write = (r_cls == CLS_STORE);
          end else begin
            o_reg_write = 1'b1;
            o_wb_sel    = (r_cls == CLS_LOAD) ? WB_MEM :
                          (r_cls == CLS_LUI)  ? WB_IMM : WB_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_halted     = (r_state == ST_HALT);
  assign o_trap       = (r_state == ST_TRAP);
  assign o_trap_cause = r_cause;
  assign o_instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into an
// expected per-cycle strobe trace from the phase rules (fetch, decode,
// execute, memory, write-back), then driven and compared cycle by cycle.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        tr = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel, trap_cause;
  logic [3:0]  alu_op;
  logic        halted, trap;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = '0;

  logic [9:0] strobes;
  assign strobes = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, wb_sel};

  multicycle_control #(.MAX_WAIT(15)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7_5(funct7_5), .i_branch_taken(branch_taken), .i_mem_ready(mem_ready),
    .i_tr(tr), .o_pc_write(pc_write), .o_pc_src(pc_src), .o_ir_write(ir_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_iord(iord),
    .o_reg_write(reg_write), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_op(alu_op), .o_wb_sel(wb_sel), .o_halted(halted), .o_trap(trap),
    .o_trap_cause(trap_cause), .o_instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, wb_sel}
  function automatic logic [9:0] mk(logic mr, logic mw, logic io, logic irw, logic pcw,
                                     logic [1:0] pcs, logic rw, logic [1:0] wb);
    return {mr, mw, io, irw, pcw, pcs, rw, wb};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; tr = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  // Drive one instruction starting in FETCH (called at posedge+1).
  // fw/mw: stalled cycles before mem_ready in fetch/memory.
  // tr_exec: raise the halt request from the EXECUTE cycle onward.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic bt, input int fw, input int mw,
                           input logic tr_exec, input string name);
    logic [9:0] exp_q[$];
    logic       rdy_q[$];
    logic       trq[$];
    int         exec_idx;
    logic       ill, chk_alu;
    logic [3:0] exp_alu;
    ill = !(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
    for (int k = 0; k <= fw; k++) begin
      exp_q.push_back(mk(1, 0, 0, k == fw, k == fw, 2'd0, 0, 2'd0));
      rdy_q.push_back(k == fw); trq.push_back(1'b0);
    end
    exp_q.push_back('0); rdy_q.push_back(1'($urandom_range(0, 1))); trq.push_back(1'b0);
    exec_idx = exp_q.size();
    if (!ill) begin
      case (op)
        OP_BRANCH: exp_q.push_back(mk(0, 0, 0, 0, bt, 2'd1, 0, 2'd0));
        OP_JAL:    exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd1, 1, 2'd2));
        OP_JALR:   exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd2, 1, 2'd2));
        default:   exp_q.push_back('0);
      endcase
      rdy_q.push_back(1'($urandom_range(0, 1))); trq.push_back(tr_exec);
      if (op == OP_LOAD || op == OP_STORE)
        for (int k = 0; k <= mw; k++) begin
          exp_q.push_back(mk(op == OP_LOAD, op == OP_STORE, 1, 0, 0, 2'd0, 0, 2'd0));
          rdy_q.push_back(k == mw); trq.push_back(tr_exec);
        end
      if (op inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC}) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 1,
                           (op == OP_LOAD) ? 2'd1 : (op == OP_LUI) ? 2'd3 : 2'd0));
        rdy_q.push_back(1'($urandom_range(0, 1))); trq.push_back(tr_exec);
      end
    end
    chk_alu = 1'b1; exp_alu = ALU_ADD;
    case (op)
      OP_R:      exp_alu = (f3 == 3'd0 || f3 == 3'd5) ? {f7, f3} : {1'b0, f3};
      OP_I:      exp_alu = (f3 == 3'd5) ? {f7, f3} : {1'b0, f3};
      OP_BRANCH: exp_alu = ALU_SUB;
      OP_LOAD, OP_STORE, OP_AUIPC, OP_JALR: exp_alu = ALU_ADD;
      default:   chk_alu = 1'b0;
    endcase
    opcode = op; funct3 = f3; funct7_5 = f7;
    for (int c = 0; c < exp_q.size(); c++) begin
      mem_ready = rdy_q[c]; tr = trq[c];
      branch_taken = (c == exec_idx) ? bt : 1'($urandom_range(0, 1));
      #2;
      n_cmp++;
      if (strobes !== exp_q[c] || halted !== 1'b0 || trap !== 1'b0) begin
        n_bad++;
        $display("FAIL %s cycle %0d: strobes %b halt %b trap %b, want strobes %b halt 0 trap 0",
                 name, c, strobes, halted, trap, exp_q[c]);
      end
      if (c == exec_idx && chk_alu && !ill) begin
        n_cmp++;
        if (alu_op !== exp_alu) begin
          n_bad++;
          $display("FAIL %s alu_op: got %0d want %0d", name, alu_op, exp_alu);
        end
      end
      @(posedge clk); #1;
    end
    if (!ill) exp_instret = exp_instret + 32'd1;
    mem_ready = 1'b0;
    n_cmp++;
    if (instret !== exp_instret) begin
      n_bad++;
      $display("FAIL %s instret: got %0d want %0d", name, instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    n_cmp++;
    if (strobes !== 10'd0 || halted !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'd0 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: strobes %b halt %b trap %b cause %0d instret %0d, want all 0",
               strobes, halted, trap, trap_cause, instret);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (mem_read !== 1'b1 || iord !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_fetch: mem_read %b iord %b, want 1 0", mem_read, iord);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async_drop: mem_read %b want 0", mem_read);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_addi();
    run_instr(OP_I, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, "addi");
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 3, 1'b0, "lw_wait");
  endtask

  task automatic test_beq();
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0, "beq_taken");
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, "beq_not_taken");
  endtask

  task automatic test_random();
    logic [6:0] ops[9];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int i = 0; i < 60; i++)
      run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, "random");
  endtask

  task automatic test_tr_halt();
    run_instr(OP_R, 3'd0, 1'b1, 1'b0, 1, 0, 1'b1, "r_with_tr");
    tr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'(i % 2);
      #2;
      n_cmp++;
      if (halted !== 1'b1 || trap !== 1'b0 || strobes !== 10'd0 || instret !== exp_instret) begin
        n_bad++;
        $display("FAIL halt_sticky: halt %b trap %b strobes %b instret %0d, want 1 0 0 %0d",
                 halted, trap, strobes, instret, exp_instret);
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || instret !== 32'd0 || mem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_reset: halt %b instret %0d mem_read %b, want 0 0 0", halted, instret, mem_read);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = '0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b1 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_refetch: mem_read %b halt %b, want 1 0", mem_read, halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(OP_I, 3'd4, 1'b0, 1'b0, 0, 0, 1'b0, "pre_illegal");
    run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 2, 0, 1'b0, "illegal");
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #2;
      n_cmp++;
      if (trap !== 1'b1 || trap_cause !== 2'd1 || strobes !== 10'd0 || halted !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_trap: trap %b cause %0d strobes %b halt %b, want 1 1 0 0",
                 trap, trap_cause, strobes, halted);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      tr = (i == 14);  // halt request colliding with the timeout: trap wins
      #2;
      n_cmp++;
      if (mem_read !== 1'b1 || trap !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_wait %0d: mem_read %b trap %b, want 1 0", i, mem_read, trap);
      end
      @(posedge clk); #1;
    end
    tr = 1'b0;
    #2;
    n_cmp++;
    if (trap !== 1'b1 || trap_cause !== 2'd2 || strobes !== 10'd0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_trap: trap %b cause %0d strobes %b halt %b, want 1 2 0 0",
               trap, trap_cause, strobes, halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_abort();
    do_reset();
    mem_ready = 1'b0; tr = 1'b1;
    #2;
    n_cmp++;
    if (mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_fetch: mem_read %b ir_write %b pc_write %b, want 1 0 0", mem_read, ir_write, pc_write);
    end
    @(posedge clk); #1;
    tr = 1'b0; mem_ready = 1'b1;
    #2;
    n_cmp++;
    if (halted !== 1'b1 || strobes !== 10'd0 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL abort_halt: halt %b strobes %b instret %0d, want 1 0 0", halted, strobes, instret);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_random();
    test_tr_halt();
    test_illegal();
    test_timeout();
    test_fetch_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
